// File: rtl/data_mem_responder_if.sv
// Load/store port between the pipeline memory stage (master) and the
// data-memory responder (slave): request handshake plus one-cycle response.
interface data_mem_responder_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_we;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_we, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_we, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word request at a time, services it
// from an internal word-addressed RAM after WAIT_CYCLES wait states and
// returns a registered one-cycle response.
//
// Optional feature macro: DATA_MEM_RESP_ERR_EN
//   defined   - out-of-range access raises resp_err, load returns 32'hDEADBEEF
//   undefined - resp_err tied 0, out-of-range load returns 0
// In both builds an out-of-range store is dropped.
module data_mem_responder #(
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 1536,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              r_req_ready;
  logic              r_busy;
  logic              r_resp_valid;
  logic              r_resp_we;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_wait_done;
  logic              w_access;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic              w_in_range;
  logic [31:0]       w_oor_rdata;
  logic              w_err;
  logic [31:0]       w_load_data;
  logic              w_mem_we;

  assign w_accept    = bus.req_valid & r_req_ready;
  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == 4'd1);

  // With no wait states the array is accessed at the accepting edge straight
  // from the request bus; otherwise from the latched copy at the last WAIT edge.
  assign w_access    = (WAIT_CYCLES == 0) ? w_accept       : w_wait_done;
  assign w_acc_we    = (WAIT_CYCLES == 0) ? bus.req_we     : r_we;
  assign w_acc_addr  = (WAIT_CYCLES == 0) ? bus.req_addr   : r_addr;
  assign w_acc_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata  : r_wdata;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign w_in_range  = {1'b0, w_acc_addr} < (ADDR_W + 1)'(DEPTH);

`ifdef DATA_MEM_RESP_ERR_EN
  assign w_oor_rdata = 32'hDEAD_BEEF;
  assign w_err       = ~w_in_range;
`else
  assign w_oor_rdata = 32'h0;
  assign w_err       = 1'b0;
`endif

  assign w_load_data = w_in_range ? r_mem[w_acc_addr] : w_oor_rdata;

  // Gated by rst_n so a store presented while reset is held is never committed.
  assign w_mem_we    = w_access & w_acc_we & w_in_range & rst_n;

  // Store port of the RAM array.
  // NOTE: the array has no reset on purpose: contents survive rst_n, and a
  // reset term would stop the tools mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  // NOTE: every state register here uses non-blocking assignment, so later
  // assignments in the block (the access override) read the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;

      case (r_state)
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        default: begin
          // IDLE and RESP both accept a new request.
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (WAIT_CYCLES != 0) begin
              r_state     <= S_WAIT;
              r_wait_cnt  <= 4'(WAIT_CYCLES);
              r_req_ready <= 1'b0;
              r_busy      <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase

      // Array access edge: complete the request and present the response.
      if (w_access) begin
        r_state      <= S_RESP;
        r_req_ready  <= 1'b1;
        r_busy       <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_we    <= w_acc_we;
        r_resp_err   <= w_err;
        if (!w_acc_we) begin
          r_resp_rdata <= w_load_data;
        end
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.busy       = r_busy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_we    = r_resp_we;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's load/store port: it accepts one word request at a time over a valid/ready handshake and services it from an internal word-addressed RAM array.
- It returns a registered response after a configurable number of wait states.
- It sits between the pipeline's memory stage and the data store, and replaces the bare altsyncram so the memory / memory_wait / ldr_writeback sequencing has an explicit response to follow.

Parameters:
ADDR_W, 11, word-address width
DEPTH, 1536, number of implemented 32-bit words (≤ 2**ADDR_W)
WAIT_CYCLES, 1, extra cycles between request acceptance and array access (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present; held stable by the requester until accepted
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  word address
req_wdata  input  32  store data
resp_valid  output  1  one-cycle pulse: request completed
resp_we  output  1  echo of the completed request's req_we, valid with resp_valid
resp_rdata  output  32  load data, valid with resp_valid for loads
resp_err  output  1  address-out-of-range flag, valid with resp_valid
busy  output  1  a request is in flight (state is WAIT)

Behaviour:
- Reset is asynchronous: state=IDLE, req_ready=1, resp_valid=0, resp_we=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0.
  - Reset drops any in-flight request; an uncommitted store is never written.
  - RAM contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- req_ready=1 in IDLE and RESP, 0 in WAIT. Accept = req_valid & req_ready at a rising edge; addr, we and wdata are latched at that edge.
- Accept with WAIT_CYCLES=0: the array access happens at the accepting edge and the next state is RESP.
- Accept with WAIT_CYCLES=k>0: next state is WAIT with counter=k.
  - Each WAIT edge decrements the counter.
  - At the edge where the counter equals 1, the array access is performed and the next state is RESP.
- Latency: resp_valid is high in the cycle following edge E0+WAIT_CYCLES, where E0 is the accept edge. This is WAIT_CYCLES+1 cycles after the accept cycle.
- Array access:
  - Load: resp_rdata <= mem[addr].
  - Store: mem[addr] <= wdata; resp_rdata holds its previous value.
- RESP lasts exactly one cycle, with no back-pressure on the response.
  - If a new request is accepted in the RESP cycle, it proceeds exactly as from IDLE. With WAIT_CYCLES=0 this gives one response per cycle.
  - Otherwise the next state is IDLE.
- resp_valid, resp_we and resp_err are 0 outside RESP. resp_rdata holds its value until the next completed load.
- Read-after-write to the same address, back to back: the load returns the new data, because the store commits at or before the load's access edge.
- req_valid while in WAIT: ignored; the requester holds it.
- Out-of-range address (addr ≥ DEPTH), base behaviour: the store is dropped, a load returns 0, and resp_err stays 0.
- Reset asserted in the same cycle as an accept: reset wins and the request is lost.

Optional Feature:
DATA_MEM_RESP_ERR_EN
- Defined: an out-of-range access drives resp_err=1 in its RESP cycle, the store is suppressed, and a load returns 32'hDEADBEEF.
- Undefined: resp_err is tied 0 and the out-of-range behaviour is as in Behaviour.

Test Plan:
- Reset mid-WAIT (WAIT_CYCLES=3): accept store 0x55 to addr 4, assert rst_n=0 one cycle later -> all outputs 0, req_ready=1; a later load of addr 4 returns its preloaded value, not 0x55.
- WAIT_CYCLES=1: preload mem[10]=38, load addr 10 -> req_ready=0 for 1 cycle, resp_valid pulses in cycle 2 after the accept cycle with resp_rdata=38, resp_we=0.
- Store 29 to addr 9, then back-to-back load addr 9 accepted in the RESP cycle -> second resp_rdata=29; req_ready never drops during RESP.
- WAIT_CYCLES=0: four consecutive loads of addrs 0..3 (preloaded 1..4) -> resp_valid high 4 consecutive cycles with data 1,2,3,4.
- req_valid held through WAIT with the address changed mid-wait -> the response uses the latched address; the new request is accepted only in RESP.
- Out-of-range load of addr 1600 -> without the macro, resp_rdata=0 and resp_err=0; with DATA_MEM_RESP_ERR_EN, resp_rdata=0xDEADBEEF and resp_err=1. An out-of-range store changes no location.
